// File: rtl/uart_pkg.sv
// Shared UART types, constants and helpers used by the TX path and bit timer.
// Define UART_TX_PARITY_EN to add the even-parity state to the TX state type.
package uart_pkg;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } txState_t;

    // Never narrower than one bit, even for the minimum oversample ratio.
    function automatic int sampleCountWidth(input int oversample);
        return (oversample <= 2) ? 1 : $clog2(oversample);
    endfunction

endpackage

// File: rtl/uart_tx_en_if.sv
// Byte handshake between the bus-side TX holding logic (master) and the transmitter (slave).
interface uart_tx_en_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_bit_timer.sv
// Oversample down-counter: counts en ticks, flags the last tick of each bit period.
// Latency: advance is combinational; reloads on request or automatically after advance.
// Backpressure: none; the counter simply holds while en is low.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int Oversample = 16
) (
    input  logic clk,
    input  logic nReset,
    input  logic en,
    input  logic reload,
    output logic advance
);

    localparam int CW = sampleCountWidth(Oversample);
    localparam logic [CW-1:0] COUNT_TOP = CW'(Oversample - 1);

    logic [CW-1:0] sampleCount;

    assign advance = en && (sampleCount == '0);

    // Reloading on advance keeps every bit exactly Oversample ticks for any ratio.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            sampleCount <= COUNT_TOP;
        end else if (reload || advance) begin
            sampleCount <= COUNT_TOP;
        end else if (en) begin
            sampleCount <= sampleCount - 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_en.sv
// 8N1 UART transmitter paced by a shared oversample en strobe (even parity with UART_TX_PARITY_EN).
// Latency: start bit on the cycle after handshake; each bit lasts Oversample en ticks.
// Backpressure: ready only in IDLE or on the final stop tick, so frames chain with no gap.
module uart_tx_en
    import uart_pkg::*;
#(
    parameter int Oversample = 16
) (
    input  logic            clk,
    input  logic            nReset,
    input  logic            en,
    uart_tx_en_if.slave     tx,
    output logic            out,
    output logic            busy,
    output logic            done
);

    txState_t   curState, nextState;
    logic [7:0] shiftReg, nextShift;
    logic [3:0] bitCount;
    logic       advance;
    logic       accept;
    logic       nextOut;
`ifdef UART_TX_PARITY_EN
    logic       parityBit;
`endif

    uart_bit_timer #(.Oversample(Oversample)) bitTimer (
        .clk     (clk),
        .nReset  (nReset),
        .en      (en),
        .reload  (accept),
        .advance (advance)
    );

    assign tx.ready = (curState == IDLE) || (curState == STOP && advance);
    assign accept   = tx.valid && tx.ready;
    assign done     = (curState == STOP) && advance;
    assign busy     = (curState != IDLE);

    always_comb begin
        nextState = curState;
        nextShift = shiftReg;
        nextOut   = UART_IDLE_LEVEL;
        case (curState)
            IDLE:  if (accept) nextState = START;
            START: if (advance) nextState = DATA;
            DATA: begin
                if (advance) begin
                    nextShift = shiftReg >> 1;
                    if (bitCount == 4'd1) begin
`ifdef UART_TX_PARITY_EN
                        nextState = PARITY;
`else
                        nextState = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (advance) nextState = STOP;
`endif
            STOP:  if (advance) nextState = tx.valid ? START : IDLE;
            default: nextState = IDLE;
        endcase
        if (accept) nextShift = tx.data;

        // Line level is registered from the next state so out lines up with curState.
        case (nextState)
            START:   nextOut = 1'b0;
            DATA:    nextOut = nextShift[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  nextOut = parityBit;
`endif
            default: nextOut = UART_IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            curState <= IDLE;
            shiftReg <= '0;
            bitCount <= 4'(UART_DATA_BITS);
            out      <= UART_IDLE_LEVEL;
        end else begin
            curState <= nextState;
            shiftReg <= nextShift;
            out      <= nextOut;
            if (curState == IDLE || curState == START) begin
                bitCount <= 4'(UART_DATA_BITS);
            end else if (curState == DATA && advance) begin
                bitCount <= bitCount - 4'd1;
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            parityBit <= 1'b0;
        end else if (accept) begin
            parityBit <= ^tx.data;
        end
    end
`endif

endmodule
